// File: rtl/crossbar_scheduler.sv
// Bank-conflict arbiter between the multiplier array and the accumulator buffer crossbar.
// Issues one batch of tagged lanes over as many cycles as bank conflicts require, at most one lane per bank per cycle.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a batch; an empty-mask batch completes in place
// ISSUE  | batch in flight; grants issue each cycle out_hold is low
module crossbar_scheduler #(
    parameter int LANES      = 16,
    parameter int BANK_COUNT = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [LANES-1:0]                       in_lane_mask,
    input  logic [LANES*$clog2(BANK_COUNT)-1:0]    in_bank,
    input  logic                                   out_hold,
    output logic [LANES-1:0]                       grant,
    output logic                                   grant_valid,
    output logic                                   batch_done,
    output logic                                   busy,
    output logic [CNT_WIDTH-1:0]                   last_issue_cycles
);

    localparam int BANK_W = $clog2(BANK_COUNT);
    localparam int PTR_W  = $clog2(LANES);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [LANES-1:0]        pending_q, pending_d;
    logic [LANES*BANK_W-1:0] bank_q, bank_d;
    logic [LANES-1:0]        grant_q, grant_d;
    logic                    grant_valid_q, grant_valid_d;
    logic                    batch_done_q, batch_done_d;
    logic [CNT_WIDTH-1:0]    last_q, last_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;

    logic [LANES-1:0]        scan_grant;
    logic [LANES-1:0]        remaining;
    logic [BANK_COUNT-1:0]   claimed;
    logic [BANK_W-1:0]       bank_sel;
    logic [CNT_WIDTH-1:0]    cnt_inc;
    logic [PTR_W-1:0]        rr_next;
    int                      lane;

    // Rotating scan: the first pending lane from rr_ptr always wins, which guarantees progress.
    always_comb begin
        scan_grant = '0;
        claimed    = '0;
        bank_sel   = '0;
        lane       = 0;
        for (int i = 0; i < LANES; i++) begin
            lane     = (int'(rr_ptr_q) + i) % LANES;
            bank_sel = bank_q[lane*BANK_W +: BANK_W];
            if (pending_q[lane] && !claimed[bank_sel]) begin
                scan_grant[lane]  = 1'b1;
                claimed[bank_sel] = 1'b1;
            end
        end
    end

    assign remaining = pending_q & ~scan_grant;
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign rr_next   = (rr_ptr_q == PTR_W'(LANES - 1)) ? '0 : rr_ptr_q + PTR_W'(1);

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        bank_d        = bank_q;
        grant_d       = '0;
        batch_done_d  = 1'b0;
        last_d        = last_q;
        cnt_d         = cnt_q;
        rr_ptr_d      = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bank_d    = in_bank;
                    pending_d = in_lane_mask;
                    cnt_d     = '0;
                    if (in_lane_mask == '0) begin
                        batch_done_d = 1'b1;
                        last_d       = '0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // Held cycles still count and still advance the pointer.
                cnt_d    = cnt_inc;
                rr_ptr_d = rr_next;
                if (!out_hold) begin
                    grant_d   = scan_grant;
                    pending_d = remaining;
                    if (remaining == '0) begin
                        state_d      = S_IDLE;
                        batch_done_d = 1'b1;
                        last_d       = cnt_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        grant_valid_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pending_q     <= '0;
            bank_q        <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            batch_done_q  <= 1'b0;
            last_q        <= '0;
            cnt_q         <= '0;
            rr_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            bank_q        <= bank_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            batch_done_q  <= batch_done_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    assign in_ready          = (state_q == S_IDLE);
    assign busy              = (state_q == S_ISSUE);
    assign grant             = grant_q;
    assign grant_valid       = grant_valid_q;
    assign batch_done        = batch_done_q;
    assign last_issue_cycles = last_q;

endmodule

// File: tb/tb_crossbar_scheduler.sv
// Self-checking bench for crossbar_scheduler: directed scenarios plus randomized traffic
// compared cycle by cycle against a lane-list reference model.
module tb_crossbar_scheduler;

    localparam int LANES      = 16;
    localparam int BANK_COUNT = 32;
    localparam int CNT_WIDTH  = 8;
    localparam int BW         = $clog2(BANK_COUNT);
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES-1:0]       in_lane_mask;
    logic [LANES*BW-1:0]    in_bank;
    logic                   out_hold;
    logic [LANES-1:0]       grant;
    logic                   grant_valid;
    logic                   batch_done;
    logic                   busy;
    logic [CNT_WIDTH-1:0]   last_issue_cycles;

    crossbar_scheduler #(
        .LANES(LANES), .BANK_COUNT(BANK_COUNT), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_mask(in_lane_mask), .in_bank(in_bank), .out_hold(out_hold),
        .grant(grant), .grant_valid(grant_valid), .batch_done(batch_done),
        .busy(busy), .last_issue_cycles(last_issue_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    bit m_busy;
    bit m_pend [LANES];
    int m_bank [LANES];
    int m_rr;
    int m_cnt;
    int m_grant;
    int m_last;
    bit m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    // Reference model: advance one clock using the inputs currently driven.
    task automatic model_step();
        bit claimed [BANK_COUNT];
        bit all_done;
        int g;
        int l;
        if (reset) begin
            m_busy = 0; m_rr = 0; m_cnt = 0; m_grant = 0; m_last = 0; m_done = 0;
            for (int i = 0; i < LANES; i++) begin m_pend[i] = 0; m_bank[i] = 0; end
            return;
        end
        m_grant = 0;
        m_done  = 0;
        if (!m_busy) begin
            if (in_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    m_pend[i] = in_lane_mask[i];
                    m_bank[i] = int'(in_bank[i*BW +: BW]);
                end
                m_cnt = 0;
                if (in_lane_mask == '0) begin m_done = 1; m_last = 0; end
                else m_busy = 1;
            end
        end else begin
            if (!out_hold) begin
                g = 0;
                for (int b = 0; b < BANK_COUNT; b++) claimed[b] = 0;
                for (int k = 0; k < LANES; k++) begin
                    l = (m_rr + k) % LANES;
                    if (m_pend[l] && !claimed[m_bank[l]]) begin
                        claimed[m_bank[l]] = 1;
                        m_pend[l] = 0;
                        g = g | (1 << l);
                    end
                end
                m_grant  = g;
                all_done = 1;
                for (int i = 0; i < LANES; i++) if (m_pend[i]) all_done = 0;
                if (all_done) begin m_busy = 0; m_done = 1; m_last = sat(m_cnt + 1); end
            end
            m_cnt = sat(m_cnt + 1);
            m_rr  = (m_rr + 1) % LANES;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("grant", 32'(grant), m_grant);
        check("grant_valid", 32'(grant_valid), 32'(m_grant != 0));
        check("batch_done", 32'(batch_done), 32'(m_done));
        check("busy", 32'(busy), 32'(m_busy));
        check("in_ready", 32'(in_ready), 32'(!m_busy));
        check("last_issue_cycles", 32'(last_issue_cycles), m_last);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic accept(input logic [LANES-1:0] mask);
        in_valid     = 1'b1;
        in_lane_mask = mask;
        tick();
        in_valid     = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (m_busy && n < 400) begin tick(); n++; end
        check("drain_idle", 32'(busy), 32'(0));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_hold = 1'b0;
        in_lane_mask = '0; in_bank = '0;
        do_reset();
        check("reset_grant", 32'(grant), 32'(0));
        check("reset_ready", 32'(in_ready), 32'(1));

        // Distinct banks: whole batch in one cycle.
        for (int i = 0; i < LANES; i++) in_bank[i*BW +: BW] = BW'(i);
        accept(16'hFFFF);
        tick();
        check("t1_grant", 32'(grant), 32'hFFFF);
        check("t1_done", 32'(batch_done), 32'(1));
        check("t1_last", 32'(last_issue_cycles), 32'(1));
        tick();
        check("t1_ready", 32'(in_ready), 32'(1));

        // Single shared bank: serialized in scan order.
        do_reset();
        for (int i = 0; i < LANES; i++) in_bank[i*BW +: BW] = BW'(5);
        accept(16'hFFFF);
        for (int k = 0; k < LANES; k++) begin
            tick();
            check("t2_grant", 32'(grant), 32'(1) << k);
        end
        check("t2_done", 32'(batch_done), 32'(1));
        check("t2_last", 32'(last_issue_cycles), 32'(16));

        // Pointer wrapped back to 0: pairs share a bank.
        for (int i = 0; i < LANES; i++) in_bank[i*BW +: BW] = BW'(i / 2);
        accept(16'hFFFF);
        tick();
        check("t3_grant0", 32'(grant), 32'h5555);
        tick();
        check("t3_grant1", 32'(grant), 32'hAAAA);
        check("t3_last", 32'(last_issue_cycles), 32'(2));

        // Backpressure for the first three issue cycles.
        do_reset();
        for (int i = 0; i < LANES; i++) in_bank[i*BW +: BW] = BW'(i);
        out_hold = 1'b1;
        accept(16'hFFFF);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_held", 32'(grant), 32'(0));
        end
        out_hold = 1'b0;
        tick();
        check("t4_grant", 32'(grant), 32'hFFFF);
        check("t4_done", 32'(batch_done), 32'(1));
        check("t4_last", 32'(last_issue_cycles), 32'(4));

        // Empty batch completes without entering ISSUE.
        accept(16'h0000);
        check("t5_done", 32'(batch_done), 32'(1));
        check("t5_last", 32'(last_issue_cycles), 32'(0));
        check("t5_ready", 32'(in_ready), 32'(1));
        tick();
        check("t5_grant", 32'(grant), 32'(0));

        // Reset mid-batch.
        do_reset();
        for (int i = 0; i < LANES; i++) in_bank[i*BW +: BW] = BW'(0);
        accept(16'hFFFF);
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_grant", 32'(grant), 32'(0));
        check("t6_busy", 32'(busy), 32'(0));
        check("t6_ready", 32'(in_ready), 32'(1));
        accept(16'hFFFF);
        tick();
        check("t6_first", 32'(grant), 32'h0001);
        drain();

        // Issue counter saturation.
        do_reset();
        out_hold = 1'b1;
        accept(16'h0001);
        for (int k = 0; k < 300; k++) tick();
        out_hold = 1'b0;
        tick();
        check("t7_last_sat", 32'(last_issue_cycles), 32'(CNT_MAX));

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int mode;
            int brange;
            reset    = ($urandom_range(0, 199) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            out_hold = ($urandom_range(0, 3) == 0);
            mode     = $urandom_range(0, 7);
            if (mode == 0)      in_lane_mask = '0;
            else if (mode == 1) in_lane_mask = '1;
            else                in_lane_mask = LANES'($urandom);
            brange = ($urandom_range(0, 1) == 1) ? 3 : BANK_COUNT - 1;
            for (int i = 0; i < LANES; i++) in_bank[i*BW +: BW] = BW'($urandom_range(0, brange));
            tick();
        end
        reset = 1'b0; in_valid = 1'b0; out_hold = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
